// File: rtl/servo_pkg.sv
// Shared constants for the servo position PWM block: parameter defaults
// and the width of the position index.
package servo_pkg;

    localparam int DEF_PERIOD    = 1000000;  // 20 ms frame at 50 MHz
    localparam int DEF_PW_MIN    = 50000;    // 1.0 ms pulse at position 0
    localparam int DEF_PW_STEP   = 5000;     // 0.1 ms per position step
    localparam int DEF_POS_MAX   = 10;
    localparam int DEF_POS_INIT  = 5;
    localparam int DEF_DB_CYCLES = 500000;   // 10 ms button settle time

    localparam int POS_W = 4;                // holds 0..POS_MAX

endpackage

// File: rtl/debounce_edge.sv
// Button debouncer plus rising-edge detector. The raw input must sit at a
// new level for DB_CYCLES consecutive cycles before the stable level
// follows it; a rise of the stable level yields a one-cycle pulse one
// cycle later. Falling edges produce nothing.
module debounce_edge
    import servo_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int DC_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DB_CYCLES - 1);

    logic            r_db;
    logic [DC_W-1:0] r_dc;
    logic            r_db_q;
    logic            r_pulse;

    // Stable-level tracking: any return to the stable level restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db <= 1'b0;
            r_dc <= '0;
        end else if (raw == r_db) begin
            r_dc <= '0;
        end else if (r_dc == DC_LAST) begin
            r_db <= raw;
            r_dc <= '0;
        end else begin
            r_dc <= r_dc + 1'b1;
        end
    end

    // Registered rising-edge detect on the stable level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_q  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_db_q  <= r_db;
            r_pulse <= r_db & ~r_db_q;
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/servo_pos_pwm.sv
// Servo position controller: two debounced buttons step a saturating
// position index, and a fixed-period PWM frame drives a pulse whose width
// tracks the position. Width changes are latched only at frame boundaries
// so a frame is never truncated or stretched mid-pulse.
module servo_pos_pwm
    import servo_pkg::*;
#(
    parameter int PERIOD    = DEF_PERIOD,
    parameter int PW_MIN    = DEF_PW_MIN,
    parameter int PW_STEP   = DEF_PW_STEP,
    parameter int POS_MAX   = DEF_POS_MAX,
    parameter int POS_INIT  = DEF_POS_INIT,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_dn,
    output logic             pwm,
    output logic [POS_W-1:0] pos,
    output logic             frame
);

    localparam int PW_MAX = PW_MIN + POS_MAX * PW_STEP;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PW_W   = $clog2(PW_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [POS_W-1:0] POS_TOP   = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_RST   = POS_W'(POS_INIT);
    localparam logic [PW_W-1:0]  WQ_RST    = PW_W'(PW_MIN + POS_INIT * PW_STEP);

    // The longest pulse must leave some low time inside every frame.
    if (PW_MAX >= PERIOD) begin : g_bad_params
        $error("servo_pos_pwm: PW_MIN + POS_MAX*PW_STEP must be below PERIOD");
    end

    logic             w_up;
    logic             w_dn;
    logic [POS_W-1:0] w_pos_next;
    logic [PW_W-1:0]  w_width;

    logic [POS_W-1:0] r_pos;
    logic [CNT_W-1:0] r_cnt;
    logic [PW_W-1:0]  r_wq;
    logic             r_pwm;

    debounce_edge #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_up),
        .pulse (w_up)
    );

    debounce_edge #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_dn),
        .pulse (w_dn)
    );

    // Saturating step; opposing pulses in the same cycle cancel.
    always_comb begin
        w_pos_next = r_pos;
        if (w_up && !w_dn && (r_pos != POS_TOP)) begin
            w_pos_next = r_pos + 1'b1;
        end else if (w_dn && !w_up && (r_pos != '0)) begin
            w_pos_next = r_pos - 1'b1;
        end
    end

    // Pulse width for the current position, sized for the widest setting.
    assign w_width = PW_W'(PW_MIN) + PW_W'(r_pos) * PW_W'(PW_STEP);

    // Position register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pos <= POS_RST;
        end else begin
            r_pos <= w_pos_next;
        end
    end

    // Frame counter, shadow width reload at the last count, and PWM compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_wq  <= WQ_RST;
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_cnt < CNT_W'(r_wq));
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_wq  <= w_width;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pwm   = r_pwm;
    assign pos   = r_pos;
    assign frame = (r_cnt == '0);

endmodule

// File: tb/tb_servo_pos_pwm.sv
// Bench for servo_pos_pwm with a short frame. The driver announces the
// expected pulse width of each frame as it starts; the monitor measures
// every completed frame (high cycles and length) and pops the expectation.
module tb_servo_pos_pwm;

    localparam int PERIOD    = 200;
    localparam int PW_MIN    = 10;
    localparam int PW_STEP   = 2;
    localparam int POS_MAX   = 10;
    localparam int POS_INIT  = 5;
    localparam int DB_CYCLES = 4;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_dn;
    logic       pwm;
    logic [3:0] pos;
    logic       frame;

    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_fail;
    int         model_pos;

    servo_pos_pwm #(
        .PERIOD    (PERIOD),
        .PW_MIN    (PW_MIN),
        .PW_STEP   (PW_STEP),
        .POS_MAX   (POS_MAX),
        .POS_INIT  (POS_INIT),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .pwm    (pwm),
        .pos    (pos),
        .frame  (frame)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    // Monitor: measure each frame between consecutive frame pulses.
    initial begin : monitor
        bit started;
        int hi_cnt;
        int cyc;
        logic [7:0] e;
        started = 0;
        hi_cnt  = 0;
        cyc     = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                started = 0;
                hi_cnt  = 0;
                cyc     = 0;
            end else if (frame) begin
                if (started) begin
                    check("frame_len", cyc, PERIOD);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL width_unexpected: got %0d high cycles, expected none queued", hi_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        check("pwm_width", hi_cnt, int'(e));
                    end
                end
                started = 1;
                cyc     = 1;
                hi_cnt  = int'(pwm);
            end else begin
                cyc++;
                hi_cnt += int'(pwm);
            end
        end
    end

    // Driver helpers.
    task automatic wait_frame();
        int t;
        t = 0;
        @(negedge clk);
        while (!frame && t < 2 * PERIOD) begin
            @(negedge clk);
            t++;
        end
        if (!frame) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: got no frame in %0d cycles, expected one every %0d", t, PERIOD);
        end
    endtask

    // Sync to a frame start, announce its width, then move to mid-frame.
    task automatic start_frame();
        wait_frame();
        exp_q.push_back(8'(PW_MIN + model_pos * PW_STEP));
        repeat (20) @(negedge clk);
    endtask

    task automatic press(input logic up, input logic dn, input int hold);
        btn_up = up;
        btn_dn = dn;
        repeat (hold) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic press_up(input string name);
        press(1'b1, 1'b0, 10);
        if (model_pos < POS_MAX) model_pos++;
        check(name, int'(pos), model_pos);
    endtask

    task automatic press_dn(input string name);
        press(1'b0, 1'b1, 10);
        if (model_pos > 0) model_pos--;
        check(name, int'(pos), model_pos);
    endtask

    // Stimulus.
    initial begin : driver
        n_checks  = 0;
        n_fail    = 0;
        model_pos = POS_INIT;
        rst       = 1'b0;
        btn_up    = 1'b0;
        btn_dn    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_pwm", int'(pwm), 0);
        check("reset_pos", int'(pos), POS_INIT);
        check("reset_frame", int'(frame), 1);
        rst = 1'b1;

        // Idle frames at the reset width.
        start_frame();
        start_frame();
        check("idle_pos", int'(pos), POS_INIT);

        // A 3-cycle blip is shorter than the debounce window.
        start_frame();
        press(1'b1, 1'b0, 3);
        check("glitch_pos", int'(pos), model_pos);

        // Both buttons together cancel.
        start_frame();
        press(1'b1, 1'b1, 10);
        check("both_pos", int'(pos), model_pos);

        // One held press mid-frame: width changes next frame only.
        start_frame();
        press_up("up_once_pos");
        repeat (30) @(negedge clk);
        check("up_once_hold_pos", int'(pos), model_pos);

        // Climb to 8, then reset in the middle of the pulse.
        start_frame();
        press_up("up_to7_pos");
        start_frame();
        press_up("up_to8_pos");
        wait_frame();
        exp_q.push_back(8'(PW_MIN + model_pos * PW_STEP));
        repeat (15) @(negedge clk);
        check("pre_reset_pwm", int'(pwm), 1);
        #1 rst = 1'b0;
        #1;
        check("midreset_pwm", int'(pwm), 0);
        check("midreset_pos", int'(pos), POS_INIT);
        check("midreset_frame", int'(frame), 1);
        exp_q.delete();
        model_pos = POS_INIT;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Saturate at the top, then at the bottom.
        for (int i = 0; i < 6; i++) begin
            start_frame();
            press_up("sat_up_pos");
        end
        for (int i = 0; i < 11; i++) begin
            start_frame();
            press_dn("sat_dn_pos");
        end

        // Final frame at the bottom width, then let the monitor drain.
        start_frame();
        wait_frame();
        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_pos_pwm.md
SERVO_POS_PWM -- requirements
Module: servo_pos_pwm

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PERIOD, 1000000, PWM frame length in clk cycles (20 ms at 50 MHz).
- PW_MIN, 50000, pulse width in cycles at pos=0.
- PW_STEP, 5000, added pulse cycles per position step.
- POS_MAX, 10, highest position index.
- POS_INIT, 5, position after reset.
- DB_CYCLES, 500000, stable cycles required to accept a button change.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1, single clock; all flops rise on posedge clk.
- rst, input, 1, asynchronous, active-low reset.
- btn_up, input, 1, already-synchronized step-up button; level, active-high.
- btn_dn, input, 1, already-synchronized step-down button; level, active-high.
- pwm, output, 1, registered servo drive pulse.
- pos, output, 4, current position index, 0..POS_MAX.
- frame, output, 1, one-cycle pulse marking the start of each PWM frame.

Function
REQ-003 Each button SHALL be debounced independently: stable level db and counter dc; if raw==db then dc<=0; else if dc==DB_CYCLES-1 then db<=raw and dc<=0; else dc<=dc+1.
REQ-004 A raw change that lasts fewer than DB_CYCLES consecutive cycles SHALL never change db.
REQ-005 A 0->1 transition of db SHALL produce a step pulse of exactly one cycle, in the cycle after db rises; a 1->0 transition SHALL produce no pulse.
REQ-006 On an up pulse with no dn pulse in the same cycle, pos SHALL become min(pos+1, POS_MAX) on the next edge.
REQ-007 On a dn pulse with no up pulse in the same cycle, pos SHALL become max(pos-1, 0) on the next edge.
REQ-008 Simultaneous up and dn pulses SHALL leave pos unchanged.
REQ-009 Frame counter cnt SHALL count 0..PERIOD-1 and then wrap to 0 unconditionally.
REQ-010 Shadow width wq SHALL load PW_MIN + pos*PW_STEP only on the edge where cnt==PERIOD-1; a pos change within a frame SHALL take effect from the next frame only.
REQ-011 On every edge, pwm SHALL be assigned (cnt < wq), so pwm is high for exactly wq cycles per frame, lagging cnt by one cycle.
REQ-012 frame SHALL be asserted for the single cycle in which cnt==0.
REQ-013 Width arithmetic SHALL be sized to hold PW_MIN + POS_MAX*PW_STEP without overflow.
REQ-014 The parameters SHALL satisfy PW_MIN + POS_MAX*PW_STEP < PERIOD; the block SHALL check this at elaboration.

Reset
REQ-015 While rst is 0, all of the following SHALL be forced asynchronously: cnt=0, wq=PW_MIN+POS_INIT*PW_STEP, pwm=0, pos=POS_INIT, db=0, dc=0, pulses=0.
REQ-016 After rst deasserts, the first edge SHALL start a frame at cnt=0, and state SHALL advance normally from there.
REQ-017 A reset asserted mid-frame SHALL drop pwm to 0 immediately, with no wait for a clock edge.

Structure
REQ-018 The parameter defaults and the position width constant SHALL live in shared package servo_pkg.
REQ-019 The debounce and rising-edge logic SHALL be sub-module debounce_edge (ports clk, rst, raw, pulse), instantiated once per button.
REQ-020 The position register, frame counter and PWM compare SHALL live in servo_pos_pwm.

Verification (PERIOD=200, PW_MIN=10, PW_STEP=2, POS_MAX=10, POS_INIT=5, DB_CYCLES=4)
REQ-021 Reset release with buttons idle -> pos=5, frame every 200 cycles, pwm high exactly 20 cycles per frame.
REQ-022 btn_up high for 3 cycles, then low -> pos stays 5 and no pulse is generated.
REQ-023 btn_up held for 10 cycles in mid-frame -> pos=6 exactly once; the current frame stays at width 20 and the next frame has width 22.
REQ-024 Six debounced up presses from pos=5 -> pos saturates at 10 (width 30); eleven dn presses -> pos=0 (width 10), with no underflow.
REQ-025 btn_up and btn_dn rise on the same cycle and are held for 10 cycles -> pos unchanged.
REQ-026 rst pulsed low at cnt=15 with pos=8 -> pwm=0 at once, pos=5, and the next frame after release is 20 cycles wide.
